eth_mii_tx: RTL and testbench

//  Free-running 100 Mb/s Ethernet frame generator driving a PHY over the MII transmit nibble bus.
//  - Sends one fixed raw Ethernet II frame (preamble, SFD, header, payload, FCS), waits an

---
 rtl/eth_pkg.sv | 34 +++
 rtl/eth_crc32_nib.sv | 22 ++
 rtl/eth_mii_tx.sv | 139 +++++++++++++
 tb/tb_eth_mii_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants, FSM encoding and nibble-wise CRC32 step
// for the MII Ethernet frame generator.
package eth_pkg;

   localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
   localparam logic [3:0]  SFD_NIB      = 4'hD;
   localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY_R   = 32'hEDB8_8320;
   localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;
   localparam int          MIN_IFG_NIB  = 24;

   typedef logic [2:0] state_t;

   localparam state_t ST_WAIT = 3'd0;
   localparam state_t ST_PRE  = 3'd1;
   localparam state_t ST_HDR  = 3'd2;
   localparam state_t ST_PAY  = 3'd3;
   localparam state_t ST_FCS  = 3'd4;

   // Reflected CRC32, one nibble, LSB first.
   function automatic logic [31:0] crc32_nib(
      input logic [31:0] c,
      input logic [3:0]  d
   );
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 4; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY_R;
         else             r = r >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/eth_crc32_nib.sv
// Running IEEE 802.3 CRC32 register, advanced one nibble per
// enabled clock; clr reloads the initial value.
module eth_crc32_nib
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        en,
   input  logic [3:0]  din,
   output logic [31:0] crc
);

   logic [31:0] crc_nx;

   always_comb crc_nx = crc32_nib(crc, din);

   always_ff @(posedge clk) begin
      if (clr)     crc <= CRC_INIT;
      else if (en) crc <= crc_nx;
   end

endmodule

// File: rtl/eth_mii_tx.sv
// Free-running MII frame generator: preamble, fixed header,
// counting payload, FCS, then an idle gap, forever.
module eth_mii_tx
   import eth_pkg::*;
#(
   parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC     = 48'h000A_3501_FEC0,
   parameter logic [15:0] ETH_TYPE    = 16'h88B5,
   parameter int          PAYLOAD_LEN = 46,
   parameter int          START_DELAY = 16,
   parameter int          GAP_CYCLES  = 200
) (
   input  logic       mii_tx_clk,
   input  logic       rst,
   output logic       mii_tx_en,
   output logic       mii_tx_er,
   output logic [3:0] mii_tx_da,
   output logic       phy_rst_n,
   input  logic       mii_rx_clk,
   input  logic       mii_rx_dv,
   input  logic       mii_rx_er,
   input  logic [3:0] mii_rx_da
);

   localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETH_TYPE};
   localparam logic [11:0] PAY_LAST = 12'(2 * PAYLOAD_LEN - 1);
   localparam int GAP_EFF =
      (GAP_CYCLES < MIN_IFG_NIB) ? MIN_IFG_NIB : GAP_CYCLES;
   localparam logic [15:0] START_LIM = 16'(START_DELAY);
   localparam logic [15:0] GAP_LIM   = 16'(GAP_EFF);

   state_t      state;
   state_t      state_nx;
   logic [11:0] idx;
   logic [11:0] idx_nx;
   logic [15:0] cnt;
   logic        first;
   logic [3:0]  nib_nx;
   logic [31:0] crc;
   logic        crc_clr;
   logic        crc_en;
   logic        rx_unused;

   assign rx_unused = ^{mii_rx_clk, mii_rx_dv, mii_rx_er, mii_rx_da};

   function automatic logic [3:0] hdr_nib(input logic [4:0] n);
      logic [7:0] b;
      b = 8'(HDR >> ((13 - int'(n[4:1])) * 8));
      return n[0] ? b[7:4] : b[3:0];
   endfunction

   function automatic logic [3:0] pay_nib(input logic [8:0] n);
      return n[0] ? n[8:5] : n[4:1];
   endfunction

   always_comb begin
      state_nx = state;
      idx_nx   = idx + 12'd1;
      unique case (state)
         ST_WAIT: begin
            idx_nx = '0;
            if (cnt == (first ? START_LIM : GAP_LIM))
               state_nx = ST_PRE;
         end
         ST_PRE: if (idx == 12'd15) begin
            state_nx = ST_HDR;
            idx_nx   = '0;
         end
         ST_HDR: if (idx == 12'd27) begin
            state_nx = ST_PAY;
            idx_nx   = '0;
         end
         ST_PAY: if (idx == PAY_LAST) begin
            state_nx = ST_FCS;
            idx_nx   = '0;
         end
         ST_FCS: if (idx == 12'd7) begin
            state_nx = ST_WAIT;
            idx_nx   = '0;
         end
         default: begin
            state_nx = ST_WAIT;
            idx_nx   = '0;
         end
      endcase
   end

   // Nibble for the position being entered; it becomes the
   // registered output and, in HDR/PAY, the CRC input.
   always_comb begin
      nib_nx = 4'h0;
      case (state_nx)
         ST_PRE: nib_nx = (idx_nx == 12'd15) ? SFD_NIB : PREAMBLE_NIB;
         ST_HDR: nib_nx = hdr_nib(idx_nx[4:0]);
         ST_PAY: nib_nx = pay_nib(idx_nx[8:0]);
         ST_FCS: nib_nx = 4'(~crc >> {idx_nx[2:0], 2'b00});
         default: nib_nx = 4'h0;
      endcase
   end

   assign crc_clr = rst || (state_nx == ST_PRE && idx_nx == 12'd15);
   assign crc_en  = (state_nx == ST_HDR) || (state_nx == ST_PAY);

   eth_crc32_nib u_crc (
      .clk (mii_tx_clk),
      .clr (crc_clr),
      .en  (crc_en),
      .din (nib_nx),
      .crc (crc)
   );

   always_ff @(posedge mii_tx_clk) begin
      if (rst) begin
         state     <= ST_WAIT;
         idx       <= '0;
         cnt       <= '0;
         first     <= 1'b1;
         mii_tx_en <= 1'b0;
         mii_tx_da <= 4'h0;
         mii_tx_er <= 1'b0;
         phy_rst_n <= 1'b0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         mii_tx_en <= (state_nx != ST_WAIT);
         mii_tx_da <= nib_nx;
         mii_tx_er <= 1'b0;
         phy_rst_n <= 1'b1;
         if (state == ST_WAIT && state_nx == ST_PRE) first <= 1'b0;
         // Gap count starts at 1 on the first idle clock so that
         // both limits compare against the same counter value.
         if (state_nx == ST_WAIT)
            cnt <= (state == ST_WAIT) ? cnt + 16'd1 : 16'd1;
         else
            cnt <= '0;
      end
   end

endmodule

// File: tb/tb_eth_mii_tx.sv
// Directed bench for eth_mii_tx: frame content, FCS/residue,
// timing, mid-frame reset and RX-pin independence.
module tb_eth_mii_tx;

   localparam int N = 1000;

   logic       clk;
   logic       rst;
   logic       tx_en;
   logic       tx_er;
   logic [3:0] tx_da;
   logic       phy_rst_n;
   logic       rx_clk;
   logic       rx_dv;
   logic       rx_er;
   logic [3:0] rx_da;

   int n_chk  = 0;
   int n_fail = 0;

   logic       en_q [N];
   logic [3:0] da_q [N];
   logic       er_q [N];
   logic       ph_q [N];
   logic       en_0 [N];
   logic [3:0] da_0 [N];
   logic [3:0] exp_nib [144];
   logic [31:0] fcs_exp;

   eth_mii_tx dut (
      .mii_tx_clk (clk),
      .rst        (rst),
      .mii_tx_en  (tx_en),
      .mii_tx_er  (tx_er),
      .mii_tx_da  (tx_da),
      .phy_rst_n  (phy_rst_n),
      .mii_rx_clk (rx_clk),
      .mii_rx_dv  (rx_dv),
      .mii_rx_er  (rx_er),
      .mii_rx_da  (rx_da)
   );

   initial begin
      clk = 1'b0;
      forever #20 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                            input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   task automatic build_exp();
      logic [7:0]   b [64];
      logic [31:0]  c;
      logic [111:0] hdr;
      hdr = {48'hFFFF_FFFF_FFFF, 48'h000A_3501_FEC0, 16'h88B5};
      c = 32'hFFFF_FFFF;
      for (int j = 0; j < 14; j++) b[j] = hdr[111 - 8 * j -: 8];
      for (int j = 0; j < 46; j++) b[14 + j] = 8'(j);
      for (int j = 0; j < 60; j++) c = crc_byte(c, b[j]);
      fcs_exp = ~c;
      for (int j = 0; j < 4; j++) b[60 + j] = fcs_exp[8 * j +: 8];
      for (int i = 0; i < 15; i++) exp_nib[i] = 4'h5;
      exp_nib[15] = 4'hD;
      for (int j = 0; j < 64; j++) begin
         exp_nib[16 + 2 * j] = b[j][3:0];
         exp_nib[17 + 2 * j] = b[j][7:4];
      end
   endtask

   task automatic capture(input int n, input bit noisy);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         en_q[k] = tx_en;
         da_q[k] = tx_da;
         er_q[k] = tx_er;
         ph_q[k] = phy_rst_n;
         if (noisy) begin
            rx_clk = 1'($urandom);
            rx_dv  = 1'($urandom);
            rx_er  = 1'($urandom);
            rx_da  = 4'($urandom);
         end
      end
   endtask

   function automatic logic [63:0] pack(input int s, input int n);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r = {r[59:0], da_q[s + i]};
      return r;
   endfunction

   function automatic int rise_at(input int from);
      for (int k = from; k < N; k++)
         if (en_q[k] === 1'b1 && (k == 0 || en_q[k - 1] === 1'b0))
            return k;
      return -1;
   endfunction

   function automatic int run_len(input int s, input logic v);
      int n;
      n = 0;
      while (s + n < N && en_q[s + n] === v) n++;
      return n;
   endfunction

   function automatic int frame_err(input int s);
      int e;
      e = 0;
      if (en_q[s - 1] !== 1'b0) e++;
      for (int i = 0; i < 144; i++)
         if (en_q[s + i] !== 1'b1 || da_q[s + i] !== exp_nib[i]) e++;
      if (en_q[s + 144] !== 1'b0) e++;
      return e;
   endfunction

   function automatic logic [31:0] fcs_obs(input int s);
      logic [31:0] f;
      f = '0;
      for (int j = 0; j < 8; j++) f[4 * j +: 4] = da_q[s + 136 + j];
      return f;
   endfunction

   initial begin
      int          cnt;
      logic [31:0] c;
      logic [31:0] rev;

      rst    = 1'b1;
      rx_clk = 1'b0;
      rx_dv  = 1'b0;
      rx_er  = 1'b0;
      rx_da  = 4'h0;
      build_exp();

      repeat (50) @(negedge clk);
      chk("rst_tx_en", 64'(tx_en), 64'd0);
      chk("rst_tx_da", 64'(tx_da), 64'd0);
      chk("rst_tx_er", 64'(tx_er), 64'd0);
      chk("rst_phy_rst_n", 64'(phy_rst_n), 64'd0);

      rst = 1'b0;
      capture(N, 1'b0);
      chk("phy_up_after_release", 64'(ph_q[0]), 64'd1);
      chk("tx_en_before_start", 64'(en_q[15]), 64'd0);
      chk("first_rise", 64'(rise_at(0)), 64'd16);
      cnt = 0;
      for (int k = 0; k < N; k++) if (er_q[k] !== 1'b0) cnt++;
      chk("tx_er_zero", 64'(cnt), 64'd0);
      chk("preamble_sfd", pack(16, 16), 64'h5555_5555_5555_555D);
      chk("dst_nibbles", pack(32, 12), 64'hFFFF_FFFF_FFFF);
      chk("src_nibbles", pack(44, 12), 64'h00A0_5310_EF0C);
      chk("ethertype", pack(56, 4), 64'h885B);
      chk("payload_byte5", pack(70, 2), 64'h50);
      chk("tx_en_len", 64'(run_len(16, 1'b1)), 64'd144);
      chk("fcs", 64'(fcs_obs(16)), 64'(fcs_exp));

      c = 32'hFFFF_FFFF;
      for (int j = 0; j < 64; j++)
         c = crc_byte(c, {da_q[33 + 2 * j], da_q[32 + 2 * j]});
      for (int i = 0; i < 32; i++) rev[i] = c[31 - i];
      chk("rx_residue", 64'(rev), 64'h0000_0000_C704_DD7B);

      chk("frame1", 64'(frame_err(16)), 64'd0);
      chk("rise2", 64'(rise_at(17)), 64'd360);
      chk("rise3", 64'(rise_at(361)), 64'd704);
      chk("rise4_none", 64'(rise_at(705)), 64'(-1));
      chk("gap1", 64'(run_len(160, 1'b0)), 64'd200);
      chk("gap2", 64'(run_len(504, 1'b0)), 64'd200);
      chk("frame2", 64'(frame_err(360)), 64'd0);
      chk("frame3", 64'(frame_err(704)), 64'd0);
      for (int k = 0; k < N; k++) begin
         en_0[k] = en_q[k];
         da_0[k] = da_q[k];
      end

      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      capture(N, 1'b1);
      rx_clk = 1'b0;
      rx_dv  = 1'b0;
      rx_er  = 1'b0;
      rx_da  = 4'h0;
      cnt = 0;
      for (int k = 0; k < N; k++)
         if (en_q[k] !== en_0[k] || da_q[k] !== da_0[k]) cnt++;
      chk("rx_pins_ignored", 64'(cnt), 64'd0);

      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      capture(87, 1'b0);
      chk("mid_nib70_en", 64'(en_q[86]), 64'd1);
      chk("mid_nib70_da", 64'(da_q[86]), 64'(exp_nib[70]));
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_tx_en", 64'(tx_en), 64'd0);
      chk("mid_rst_phy", 64'(phy_rst_n), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      capture(N, 1'b0);
      chk("mid_first_rise", 64'(rise_at(0)), 64'd16);
      chk("mid_tx_en_len", 64'(run_len(16, 1'b1)), 64'd144);
      chk("mid_frame", 64'(frame_err(16)), 64'd0);
      chk("mid_fcs", 64'(fcs_obs(16)), 64'(fcs_exp));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
